// File: rtl/computef_selftest_ctrl.sv
// computef_selftest_ctrl
// Built-in self-test sequencer for the CMOS function block F = ~(A&D | E&(B|C)).
// Walks all 32 input vectors onto the block, holds each for SETTLE_CYCLES,
// samples F for one cycle and compares it with the golden function. Reports
// the mismatch count, the first failing vector and an overall pass flag.
// Vector bit order: [4]=A, [3]=B, [2]=C, [1]=D, [0]=E.

module computef_selftest_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    output logic [4:0] vec_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [4:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Counter reload value; SETTLE lasts reload+1 cycles, i.e. SETTLE_CYCLES.
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [4:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] err_q, err_d;
    logic [4:0] ffv_q, ffv_d;
    logic       ffvalid_q, ffvalid_d;

    logic golden;
    logic mismatch;

    // Golden response for the vector currently on the bus; case-inequality
    // makes an undriven or unknown F count as a failure.
    always_comb begin
        golden   = ~((vec_q[4] & vec_q[1]) | (vec_q[0] & (vec_q[3] | vec_q[2])));
        mismatch = (f_in !== golden);
    end

    // Sequencer next-state: start from IDLE/DONE clears results and begins at
    // vector 0; abort while busy returns to IDLE without recording the sample.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SETTLE;
                    vec_d     = 5'd0;
                    cnt_d     = SETTLE_RELOAD;
                    err_d     = 6'd0;
                    ffv_d     = 5'd0;
                    ffvalid_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + 6'd1;
                        if (!ffvalid_q) begin
                            ffv_d     = vec_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    if (vec_q == 5'd31) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 5'd1;
                        cnt_d   = SETTLE_RELOAD;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any run in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_q     <= 5'd0;
            cnt_q     <= 4'd0;
            err_q     <= 6'd0;
            ffv_q     <= 5'd0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    // Outputs decoded from state; the stimulus bus is parked at 0 when idle.
    always_comb begin
        busy             = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        done             = (state_q == ST_DONE);
        pass             = done && (err_q == 6'd0);
        vec_out          = busy ? vec_q : 5'd0;
        err_count        = err_q;
        first_fail_vec   = ffv_q;
        first_fail_valid = ffvalid_q;
    end

endmodule

// File: tb/tb_computef_selftest_ctrl.sv
// tb_computef_selftest_ctrl
// Bench for the self-test sequencer. A behavioural model of the function block
// (correct, stuck, inverted, floating or random responses) answers the DUT's
// stimulus, and expected results are derived from a truth-table count.

module tb_computef_selftest_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, fIn;
    logic [4:0] vecOut;
    logic       busy, done, pass;
    logic [5:0] errCount;
    logic [4:0] ffVec;
    logic       ffValid;

    logic       start1, abort1, fIn1;
    logic [4:0] vecOut1;
    logic       busy1, done1, pass1;
    logic [5:0] errCount1;
    logic [4:0] ffVec1;
    logic       ffValid1;

    int   fMode;
    logic randF [32];

    int checks = 0;
    int errors = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    computef_selftest_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(fIn),
        .vec_out(vecOut), .busy(busy), .done(done), .pass(pass),
        .err_count(errCount), .first_fail_vec(ffVec), .first_fail_valid(ffValid)
    );

    computef_selftest_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(fIn1),
        .vec_out(vecOut1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(errCount1), .first_fail_vec(ffVec1), .first_fail_valid(ffValid1)
    );

    // Reference function: F is 0 exactly when A&D or E&(B|C) holds.
    function automatic logic goldenF(input int v);
        int a, b, c, d, e;
        a = (v >> 4) & 1;
        b = (v >> 3) & 1;
        c = (v >> 2) & 1;
        d = (v >> 1) & 1;
        e = v & 1;
        return ((a * d + e * (b | c)) == 0) ? 1'b1 : 1'b0;
    endfunction

    // Response of the block under test in each fault mode.
    function automatic logic respF(input int mode, input int v);
        case (mode)
            0:       return goldenF(v);
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return 1'bz;
            4:       return ~goldenF(v);
            default: return randF[v];
        endcase
    endfunction

    // The block under test answers whatever vector the sequencer drives.
    always_comb begin
        fIn  = respF(fMode, int'(vecOut));
        fIn1 = goldenF(int'(vecOut1));
    end

    // Expected result for vectors 0..upto-1 fully sampled.
    task automatic modelRun(input int mode, input int upto,
                            output int expErr, output int expFfv, output bit expValid);
        expErr = 0; expFfv = 0; expValid = 0;
        for (int v = 0; v < upto; v++) begin
            if (respF(mode, v) !== goldenF(v)) begin
                expErr++;
                if (!expValid) begin
                    expFfv = v;
                    expValid = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; start1 = 0; abort1 = 0; fMode = 0;
        #2;
        checks++; if (vecOut !== 5'd0) begin errors++; $display("[TB] FAIL reset_vec_out: got %0d expected 0", vecOut); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %0b expected 0", pass); end
        checks++; if (errCount !== 6'd0) begin errors++; $display("[TB] FAIL reset_err_count: got %0d expected 0", errCount); end
        checks++; if (ffVec !== 5'd0) begin errors++; $display("[TB] FAIL reset_first_fail_vec: got %0d expected 0", ffVec); end
        checks++; if (ffValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_first_fail_valid: got %0b expected 0", ffValid); end
        checks++; if ({busy1, done1, vecOut1, errCount1} !== 13'd0) begin errors++; $display("[TB] FAIL reset_dut1: got %0h expected 0", {busy1, done1, vecOut1, errCount1}); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Full 32-vector run; optionally raises abort alongside start to show start wins.
    task automatic runFull(input int mode, input bit withAbort, input string name);
        int expErr, expFfv, ticks, seqBad;
        bit expValid;
        modelRun(mode, 32, expErr, expFfv, expValid);
        start = 1; abort = withAbort;
        tick();
        start = 0; abort = 0;
        checks++; if ({busy, done, errCount, ffValid} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin errors++; $display("[TB] FAIL %s_start_clear: got busy=%0b done=%0b err=%0d ffvalid=%0b expected 1 0 0 0", name, busy, done, errCount, ffValid); end
        ticks = 1; seqBad = 0;
        while (done !== 1'b1 && ticks <= 400) begin
            if (busy !== 1'b1 || vecOut !== 5'((ticks - 1) / 3)) seqBad++;
            tick();
            ticks++;
        end
        checks++; if (seqBad != 0) begin errors++; $display("[TB] FAIL %s_vec_seq: got %0d bad cycles expected 0", name, seqBad); end
        checks++; if (ticks - 1 != 96) begin errors++; $display("[TB] FAIL %s_run_length: got %0d cycles expected 96", name, ticks - 1); end
        checks++; if (errCount !== 6'(expErr)) begin errors++; $display("[TB] FAIL %s_err_count: got %0d expected %0d", name, errCount, expErr); end
        checks++; if (ffValid !== expValid) begin errors++; $display("[TB] FAIL %s_first_fail_valid: got %0b expected %0b", name, ffValid, expValid); end
        checks++; if (ffVec !== 5'(expFfv)) begin errors++; $display("[TB] FAIL %s_first_fail_vec: got %0d expected %0d", name, ffVec, expFfv); end
        checks++; if (pass !== (expErr == 0)) begin errors++; $display("[TB] FAIL %s_pass: got %0b expected %0b", name, pass, expErr == 0); end
        checks++; if ({busy, vecOut} !== 6'd0) begin errors++; $display("[TB] FAIL %s_done_idle_bus: got busy=%0b vec=%0d expected 0 0", name, busy, vecOut); end
    endtask

    task automatic test_correct();
        fMode = 0;
        runFull(0, 0, "correct");
    endtask

    task automatic test_stuck();
        fMode = 1; runFull(1, 0, "tie1");
        fMode = 2; runFull(2, 0, "tie0");
        fMode = 3; runFull(3, 0, "floating");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 32; v++) randF[v] = logic'($urandom_range(0, 1));
            fMode = 5;
            runFull(5, 0, "random");
        end
    endtask

    // Inverted block, results held in DONE while abort is ignored, then restart.
    task automatic test_back_to_back();
        fMode = 4;
        runFull(4, 0, "inverted");
        abort = 1;
        repeat (3) tick();
        abort = 0;
        checks++; if ({done, errCount, ffVec} !== {1'b1, 6'd32, 5'd0}) begin errors++; $display("[TB] FAIL done_hold: got done=%0b err=%0d ffv=%0d expected 1 32 0", done, errCount, ffVec); end
        runFull(4, 1, "rerun");
    endtask

    // Abort at a chosen vector/phase (0,1 settle, 2 sample), optionally with start noise.
    task automatic runAbort(input int mode, input int abortVec, input int phase,
                            input bit noisy, input string name);
        int expErr, expFfv, ticks, seqBad;
        bit expValid;
        modelRun(mode, abortVec, expErr, expFfv, expValid);
        start = 1;
        tick();
        start = 0;
        ticks = 1; seqBad = 0;
        while (ticks - 1 < abortVec * 3 + phase && ticks <= 400) begin
            if (busy !== 1'b1 || vecOut !== 5'((ticks - 1) / 3)) seqBad++;
            if (noisy) start = logic'($urandom_range(0, 1));
            tick();
            ticks++;
        end
        checks++; if (seqBad != 0) begin errors++; $display("[TB] FAIL %s_vec_seq: got %0d bad cycles expected 0", name, seqBad); end
        start = 0; abort = 1;
        tick();
        abort = 0;
        checks++; if ({busy, done, vecOut} !== 7'd0) begin errors++; $display("[TB] FAIL %s_idle: got busy=%0b done=%0b vec=%0d expected 0 0 0", name, busy, done, vecOut); end
        checks++; if (errCount !== 6'(expErr)) begin errors++; $display("[TB] FAIL %s_err_count: got %0d expected %0d", name, errCount, expErr); end
        checks++; if ({ffValid, ffVec} !== {expValid, 5'(expFfv)}) begin errors++; $display("[TB] FAIL %s_first_fail: got %0b/%0d expected %0b/%0d", name, ffValid, ffVec, expValid, expFfv); end
        repeat (2) tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL %s_stays_idle: got busy=%0b done=%0b expected 0 0", name, busy, done); end
    endtask

    task automatic test_abort();
        fMode = 0;
        runAbort(0, 10, 0, 1, "abort_v10");
        for (int r = 0; r < 2; r++) begin
            fMode = $urandom_range(1, 4);
            runAbort(fMode, $urandom_range(1, 30), $urandom_range(0, 2), 1, "abort_rand");
        end
    endtask

    task automatic test_reset_midrun();
        int expErr, expFfv, ticks;
        bit expValid;
        fMode = 1;
        modelRun(1, 20, expErr, expFfv, expValid);
        start = 1;
        tick();
        start = 0;
        ticks = 1;
        while (ticks - 1 < 60) begin
            tick();
            ticks++;
        end
        checks++; if ({vecOut, errCount} !== {5'd20, 6'(expErr)}) begin errors++; $display("[TB] FAIL midrun_state: got vec=%0d err=%0d expected 20 %0d", vecOut, errCount, expErr); end
        #2;
        rst_n = 0;
        #1;
        checks++; if ({vecOut, busy, done, pass, errCount, ffVec, ffValid} !== 20'd0) begin errors++; $display("[TB] FAIL async_reset: got %0h expected 0", {vecOut, busy, done, pass, errCount, ffVec, ffValid}); end
        repeat (2) tick();
        rst_n = 1;
        repeat (3) tick();
        checks++; if ({busy, done, vecOut, errCount} !== 13'd0) begin errors++; $display("[TB] FAIL reset_release_idle: got %0h expected 0", {busy, done, vecOut, errCount}); end
    endtask

    task automatic test_settle_one();
        int ticks;
        start1 = 1;
        tick();
        start1 = 0;
        ticks = 1;
        while (done1 !== 1'b1 && ticks <= 300) begin
            tick();
            ticks++;
        end
        checks++; if (ticks - 1 != 64) begin errors++; $display("[TB] FAIL settle1_run_length: got %0d cycles expected 64", ticks - 1); end
        checks++; if ({pass1, errCount1, ffValid1} !== {1'b1, 6'd0, 1'b0}) begin errors++; $display("[TB] FAIL settle1_result: got pass=%0b err=%0d ffvalid=%0b expected 1 0 0", pass1, errCount1, ffValid1); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck();
        test_back_to_back();
        test_random();
        test_abort();
        test_reset_midrun();
        test_settle_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
